fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0: PC value loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 4: instruction-queue entries; power of two, at least 2.
REQ-003 SHALL have port CLK  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port halt  in  1  stop issuing new fetches.
REQ-006 SHALL have port redirect  in  1  taken branch/jump/jr resolved downstream.
REQ-007 SHALL have port redirect_pc  in  32  new fetch address.
REQ-008 SHALL have port imemREN  out  1  instruction-memory read request.
REQ-009 SHALL have port imemaddr  out  32  request address (current PC).
REQ-010 SHALL have port ihit  in  1  memory returns imemload this cycle.
REQ-011 SHALL have port imemload  in  32  fetched instruction.
REQ-012 SHALL have port deq  in  1  decode consumes the queue head.
REQ-013 SHALL have port out_valid  out  1  queue non-empty.
REQ-014 SHALL have ports out_instr, out_pc, out_npc  out  32 each  head entry {instr, pc, pc+4}.

Function
REQ-015 SHALL hold PC in a register; imemaddr SHALL equal PC combinationally.
REQ-016 imemREN SHALL equal !halt && !full && !redirect.
REQ-017 On ihit with imemREN=1, the unit SHALL push {imemload, PC, PC+4} and set PC <= PC+4 at the same edge.
REQ-018 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h0).
REQ-019 ihit while imemREN=0 SHALL be ignored (no push, PC unchanged).
REQ-020 Request SHALL be held stable (same imemaddr) over any number of wait cycles until ihit.
REQ-021 redirect=1 SHALL at that edge empty the queue, set PC <= {redirect_pc[31:2], 2'b00}, and drop any same-cycle ihit and deq.
REQ-022 The cycle after redirect, imemREN SHALL reassert (if !halt) with imemaddr = the new PC.
REQ-023 deq with out_valid=1 SHALL pop the head; deq when empty SHALL be ignored.
REQ-024 Push and pop in the same cycle SHALL leave the count unchanged and be legal when full (pop frees the slot; imemREN still 0 that cycle since full is registered state).
REQ-025 full SHALL be count==DEPTH; out_valid SHALL be count!=0; count width $clog2(DEPTH)+1.
REQ-026 out_instr/out_pc/out_npc SHALL be 32'h0 when out_valid=0.
REQ-027 halt SHALL not block deq; queue drains while halted; redirect overrides halt for PC update.
REQ-028 Queue order SHALL be strict FIFO; pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 On nRST=0, immediately: PC=PC_INIT, queue count and pointers = 0, out_valid=0, out_* = 0.
REQ-030 Reset mid-request SHALL abandon the request; a late ihit after reset release SHALL be treated as a hit for PC_INIT.
REQ-031 Queue storage array SHALL NOT require reset.

Structure
REQ-032 Shared package cpu_types_pkg SHALL hold word_t (32-bit) and fetch_entry_t {instr, pc, npc}.
REQ-033 The queue SHALL be sub-module fetch_fifo (parameter DEPTH; push, pop, flush, full, empty, head); PC and request logic in fetch_unit.

Verification
REQ-034 Reset, PC_INIT=0, ihit=1 every cycle, deq=0 -> imemaddr 0,4,8,12; queue full after 4 pushes; imemREN=0 thereafter.
REQ-035 Full queue, deq=1 one cycle -> out_pc advances 0->4, count 3, imemREN=1 next cycle, fetch of 16 pushed.
REQ-036 ihit low 3 cycles at PC=8 -> imemaddr stays 8, no push; push on 4th cycle ihit.
REQ-037 Queue holding 3 entries, redirect=1 with redirect_pc=32'h0000_0103 and ihit=1 -> out_valid=0 next cycle, imemaddr=32'h0000_0100, dropped instruction never appears.
REQ-038 PC=32'hFFFF_FFFC, ihit -> entry npc=0, next imemaddr=0.
REQ-039 halt=1 with 2 entries, deq=1 two cycles -> both drained in order, imemREN=0, PC unchanged; nRST pulse mid-stream -> PC=PC_INIT, out_valid=0 immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the fetch-queue entry.
// Also holds the sequential-PC helper used by fetch.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t instr;
      word_t pc;
      word_t npc;
   } fetch_entry_t;

   localparam word_t INSTR_BYTES = 32'd4;

   // Wraps modulo 2^32, so the last word rolls over to address 0.
   function automatic word_t pc_plus4(input word_t pc);
      return pc + INSTR_BYTES;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface fetch_unit_if;
   import cpu_types_pkg::*;

   logic  imemREN;
   word_t imemaddr;
   logic  ihit;
   word_t imemload;

   modport master (output imemREN, imemaddr, input ihit, imemload);
   modport slave  (input imemREN, imemaddr, output ihit, imemload);
endinterface

// File: rtl/fetch_fifo.sv
// Instruction queue: strict FIFO with flush, simultaneous push/pop when full.
// Storage has no reset; head reads as zero whenever the queue is empty.
module fetch_fifo
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_data,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic          do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = empty ? '0 : mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot, so a push into a full queue is accepted.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues imem reads and queues {instr, pc, pc+4}.
// A downstream redirect flushes the queue and restarts fetch at the target.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0,
   parameter int    DEPTH   = 4
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          halt,
   input  logic          redirect,
   input  word_t         redirect_pc,
   fetch_unit_if.master  imem,
   input  logic          deq,
   output logic          out_valid,
   output word_t         out_instr,
   output word_t         out_pc,
   output word_t         out_npc
);

   word_t        pc_q, pc_d;
   logic         ren, push, pop, full, empty;
   fetch_entry_t push_entry, head;
   logic         unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Request stays up with the same address until ihit; redirect suppresses it
   // so the target is fetched the following cycle.
   assign ren           = !halt && !full && !redirect;
   assign imem.imemREN  = ren;
   assign imem.imemaddr = pc_q;

   assign push = ren && imem.ihit;
   assign pop  = deq && !redirect;

   assign push_entry = '{instr: imem.imemload, pc: pc_q, npc: pc_plus4(pc_q)};

   always_comb begin
      pc_d = pc_q;
      if (redirect)
         pc_d = {redirect_pc[31:2], 2'b00};
      else if (push)
         pc_d = pc_plus4(pc_q);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) pc_q <= PC_INIT;
      else       pc_q <= pc_d;
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK       (CLK),
      .nRST      (nRST),
      .push      (push),
      .pop       (pop),
      .flush     (redirect),
      .push_data (push_entry),
      .full      (full),
      .empty     (empty),
      .head      (head)
   );

   assign out_valid = !empty;
   assign out_instr = head.instr;
   assign out_pc    = head.pc;
   assign out_npc   = head.npc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus records expected queue entries,
// a negedge monitor checks occupancy and every dequeued entry in order.
module tb_fetch_unit;
   import cpu_types_pkg::*;

   logic  CLK = 1'b0;
   logic  nRST;
   logic  halt, redirect, deq;
   word_t redirect_pc;
   logic  out_valid;
   word_t out_instr, out_pc, out_npc;

   int checks = 0;
   int errors = 0;
   fetch_entry_t exp_q[$];

   fetch_unit_if ifc();

   fetch_unit #(.PC_INIT(32'h0), .DEPTH(4)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .halt        (halt),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem        (ifc),
      .deq         (deq),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_npc     (out_npc)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: queue occupancy must track the scoreboard; each dequeue must match its head.
   always @(negedge CLK) begin
      if (nRST) begin
         chk("occupancy", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
         if (deq && out_valid && !redirect) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_deq: got pc %h expected empty queue", out_pc);
            end else begin
               chk("head_instr", out_instr, exp_q[0].instr);
               chk("head_pc",    out_pc,    exp_q[0].pc);
               chk("head_npc",   out_npc,   exp_q[0].npc);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // One cycle: inputs already driven; check request at negedge, record push at posedge.
   task automatic step(input bit e_ren, input word_t e_addr, input bit e_push,
                       input word_t e_instr, input word_t e_pc, input word_t e_npc);
      fetch_entry_t e;
      @(negedge CLK);
      chk("imemREN",  {31'b0, ifc.imemREN}, {31'b0, e_ren});
      chk("imemaddr", ifc.imemaddr, e_addr);
      @(posedge CLK);
      if (redirect) exp_q.delete();
      if (e_push) begin
         e = '{e_instr, e_pc, e_npc};
         exp_q.push_back(e);
      end
      #1;
   endtask

   task automatic idle_inputs();
      halt = 0; redirect = 0; deq = 0; redirect_pc = '0;
      ifc.ihit = 0; ifc.imemload = '0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_imemaddr"},  ifc.imemaddr, 32'h0);
      chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
      chk({tag, "_out_instr"}, out_instr, 32'h0);
      chk({tag, "_out_pc"},    out_pc, 32'h0);
      chk({tag, "_out_npc"},   out_npc, 32'h0);
   endtask

   // Asynchronous reset pulse placed mid-cycle, away from any edge.
   task automatic reset_pulse(input string tag);
      #1 nRST = 0;
      exp_q.delete();
      #1 check_reset_state(tag);
      @(posedge CLK);
      #3 nRST = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish within 200000");
      $fatal(1, "timeout");
   end

   initial begin
      word_t instrs [4];
      instrs = '{32'h2001_0001, 32'h2002_0002, 32'h2003_0003, 32'h2004_0004};
      idle_inputs();
      nRST = 0;
      #3 check_reset_state("reset");
      chk("reset_imemREN", {31'b0, ifc.imemREN}, 32'h1);
      #9 nRST = 1;
      @(posedge CLK); #1;

      // Fill: addresses 0,4,8,12 pushed back to back, then full stops requests.
      for (int k = 0; k < 4; k++) begin
         ifc.ihit = 1; ifc.imemload = instrs[k];
         step(1, word_t'(k * 4), 1, instrs[k], word_t'(k * 4), word_t'(k * 4 + 4));
      end
      ifc.imemload = 32'hBAD0_0010;
      step(0, 32'h10, 0, 0, 0, 0);
      step(0, 32'h10, 0, 0, 0, 0);
      chk("full_head_pc", out_pc, 32'h0);

      // One dequeue from full: head advances, fetch of 16 proceeds next cycle.
      deq = 1;
      step(0, 32'h10, 0, 0, 0, 0);
      deq = 0;
      chk("after_deq_pc", out_pc, 32'h4);
      ifc.imemload = 32'h2005_0010;
      step(1, 32'h10, 1, 32'h2005_0010, 32'h10, 32'h14);
      ifc.ihit = 0;
      step(0, 32'h14, 0, 0, 0, 0);

      // Drain all four; empty queue presents zeros.
      deq = 1;
      step(0, 32'h14, 0, 0, 0, 0);
      step(1, 32'h14, 0, 0, 0, 0);
      step(1, 32'h14, 0, 0, 0, 0);
      step(1, 32'h14, 0, 0, 0, 0);
      deq = 0;
      chk("drained_valid", {31'b0, out_valid}, 32'h0);
      chk("drained_instr", out_instr, 32'h0);

      // Wait states at PC=8, then redirect with three entries queued.
      idle_inputs();
      reset_pulse("rst2");
      @(posedge CLK); #1;
      ifc.ihit = 1; ifc.imemload = 32'h3000_0000;
      step(1, 32'h0, 1, 32'h3000_0000, 32'h0, 32'h4);
      ifc.imemload = 32'h3000_0004;
      step(1, 32'h4, 1, 32'h3000_0004, 32'h4, 32'h8);
      ifc.ihit = 0; ifc.imemload = 32'hBAD0_0008;
      for (int k = 0; k < 3; k++) step(1, 32'h8, 0, 0, 0, 0);
      ifc.ihit = 1; ifc.imemload = 32'h3000_0008;
      step(1, 32'h8, 1, 32'h3000_0008, 32'h8, 32'hC);
      redirect = 1; redirect_pc = 32'h0000_0103; deq = 1; ifc.imemload = 32'hDEAD_BEEF;
      step(0, 32'hC, 0, 0, 0, 0);
      redirect = 0; deq = 0;
      chk("redirect_flush_valid", {31'b0, out_valid}, 32'h0);
      ifc.imemload = 32'h3000_0100;
      step(1, 32'h100, 1, 32'h3000_0100, 32'h100, 32'h104);
      deq = 1; ifc.imemload = 32'h3000_0104;
      step(1, 32'h104, 1, 32'h3000_0104, 32'h104, 32'h108);
      ifc.ihit = 0;
      step(1, 32'h108, 0, 0, 0, 0);
      deq = 0;

      // Top-of-address-space wrap.
      redirect = 1; redirect_pc = 32'hFFFF_FFFC;
      step(0, 32'h108, 0, 0, 0, 0);
      redirect = 0; ifc.ihit = 1; ifc.imemload = 32'h4000_FFFC;
      step(1, 32'hFFFF_FFFC, 1, 32'h4000_FFFC, 32'hFFFF_FFFC, 32'h0);
      ifc.imemload = 32'h4000_0000;
      step(1, 32'h0, 1, 32'h4000_0000, 32'h0, 32'h4);
      ifc.ihit = 0; deq = 1;
      step(1, 32'h4, 0, 0, 0, 0);
      step(1, 32'h4, 0, 0, 0, 0);
      deq = 0;

      // Halt with two entries: drains in order, PC frozen, redirect still lands.
      ifc.ihit = 1; ifc.imemload = 32'h5000_0004;
      step(1, 32'h4, 1, 32'h5000_0004, 32'h4, 32'h8);
      ifc.imemload = 32'h5000_0008;
      step(1, 32'h8, 1, 32'h5000_0008, 32'h8, 32'hC);
      halt = 1; ifc.imemload = 32'hBAD0_000C;
      step(0, 32'hC, 0, 0, 0, 0);
      deq = 1;
      step(0, 32'hC, 0, 0, 0, 0);
      step(0, 32'hC, 0, 0, 0, 0);
      step(0, 32'hC, 0, 0, 0, 0);
      deq = 0;
      chk("halt_empty_pc", out_pc, 32'h0);
      redirect = 1; redirect_pc = 32'h0000_0040;
      step(0, 32'hC, 0, 0, 0, 0);
      redirect = 0;
      step(0, 32'h40, 0, 0, 0, 0);
      halt = 0; ifc.imemload = 32'h6000_0040;
      step(1, 32'h40, 1, 32'h6000_0040, 32'h40, 32'h44);

      // Reset mid-stream with ihit held; the late hit is taken for PC_INIT.
      ifc.imemload = 32'h7000_0000;
      reset_pulse("rst3");
      step(1, 32'h0, 1, 32'h7000_0000, 32'h0, 32'h4);
      ifc.ihit = 0; deq = 1;
      step(1, 32'h4, 0, 0, 0, 0);
      deq = 0;
      chk("scoreboard_empty", exp_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
